sync_down_counter: RTL
======================

Name: sync_down_counter

Overview:
- Presettable synchronous down-counter/timer. It is the decrementing counterpart to the team's 4-bit up-counter and uses the same Load/En_P/En_T control style.
- Counts down from a loaded preset and signals underflow.
- Supports one-shot (stop at zero) and auto-reload (programmable divide-by-N+1) modes.
- Exposes a cascade borrow so multiple stages chain into wider timers.

Parameters:
WIDTH, 4, counter and preset width in bits (>=2)

Ports:
Clock  input  1  sole clock; all state updates on its rising edge
Clear  input  1  reset; synchronous, active-high
Load  input  1  active-low synchronous load of D_in into counter and preset register
En_P  input  1  count enable (parallel)
En_T  input  1  count enable (trickle); also gates Bout
Auto_Reload  input  1  1 = reload preset on underflow; 0 = one-shot, stop in DONE
D_in  input  WIDTH  preset value
D_out  output  WIDTH  current count
Bout  output  1  combinational cascade borrow
Uf_Pulse  output  1  registered one-cycle pulse, cycle after each underflow event
Done  output  1  registered; high while FSM in DONE
Uf_Sticky  output  1  sticky underflow flag (optional feature)

Behaviour:
- Priority each edge: Clear > Load (low) > counting.
- Clear=1: count=0, preset=0, state=IDLE. Done=0, Uf_Pulse=0, Uf_Sticky=0. Applies mid-count in any state.
- Load=0 (Clear=0):
  - count=D_in, preset=D_in, state=RUN, Done=0, Uf_Pulse=0.
  - Overrides enables and any underflow in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE: holds count. Ignores En_P/En_T/Auto_Reload. Exits only via Load.
- RUN, with En_P&En_T=1:
  - count!=0: count <= count-1.
  - count==0: underflow event. Uf_Pulse=1 next cycle.
    - Auto_Reload=1: count <= preset, stay RUN.
    - Auto_Reload=0: count stays 0, state <= DONE, Done=1.
- RUN with En_P&En_T=0: hold count; Uf_Pulse=0.
- DONE: count holds 0, Done=1, enables ignored. Exits via Load or Clear only.
- Period and arithmetic:
  - Underflow period in auto-reload = preset+1 enabled cycles.
  - preset=0 with auto-reload underflows every enabled cycle.
  - Decrement is modulo 2^WIDTH but never wraps; zero is always handled as underflow.
- Auto_Reload is sampled only at the underflow cycle and may change freely otherwise.
- Bout = (state==RUN) & En_T & (count==0). It is purely combinational, for cascading.
- Cascading: lower stage Bout drives the upper stage En_T. En_P is common.
- Uf_Pulse is exactly one cycle wide. Consecutive underflows (preset=0) keep it high continuously.
- Reset values: D_out=0, Bout=0, Uf_Pulse=0, Done=0, Uf_Sticky=0.

Optional Feature:
- Macro SYNC_DOWN_CNT_UF_STICKY_EN.
- Defined:
  - Uf_Sticky sets on any underflow event.
  - Holds until Clear or Load.
  - Load in the same cycle as an underflow clears it; Load wins.
- Undefined: Uf_Sticky tied to 0 and no flop is inferred.
- Port list is identical in both builds.

Decomposition:
- Shared package sync_down_counter_pkg holds:
  - state enum/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the state width constant.
- One sub-module is natural: down_cnt_core.
  - Contents: WIDTH-wide register with load, decrement and zero-detect.
  - Outputs: count, is_zero.
  - Top holds the FSM, preset register, flags and Bout.

Test Plan:
- Clear=1 two cycles, then Clear=0 and pulse enables -> D_out=0, Done=0, state IDLE, count stays 0, Bout=0.
- Load D_in=3, Auto_Reload=0, En_P=En_T=1 -> D_out 3,2,1,0. Bout=1 while D_out=0. Next edge Uf_Pulse=1 for one cycle, Done=1, D_out stays 0 forever.
- Load D_in=2, Auto_Reload=1, enables high 9 cycles -> D_out 2,1,0,2,1,0,2,1,0. Uf_Pulse high one cycle after each 0 (period 3). Done stays 0.
- Load 5, count to 3, drop En_T for 4 cycles -> D_out holds 3, Bout=0. Restore -> continues 2,1,0.
- Clear=1 while RUN at count 4, same cycle as Load=0 -> Clear wins: D_out=0, IDLE. Also Load=0 at the underflow cycle with D_in=7 -> D_out=7, RUN, Uf_Pulse=0.
- Macro defined: two-stage cascade (WIDTH=4 each, preset 0x01,0x02). Upper En_T driven by lower Bout; upper decrements only when lower is 0. Uf_Sticky sets on first underflow and clears only on Load/Clear. Macro undefined: Uf_Sticky always 0.

Source files
------------

// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the presettable synchronous down-counter.
package sync_down_counter_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/down_cnt_core.sv
// WIDTH-bit count register with load, decrement and zero detect.
// Load has priority over decrement; the caller never requests a decrement at zero.
module down_cnt_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_zero
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: load, decrement or hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge Clock) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign is_zero = (count_q == '0);

endmodule

// File: rtl/sync_down_counter.sv
// Presettable synchronous down-counter/timer with one-shot and auto-reload modes.
// Optional sticky underflow flag: define SYNC_DOWN_CNT_UF_STICKY_EN.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Load,
    input  logic             En_P,
    input  logic             En_T,
    input  logic             Auto_Reload,
    input  logic [WIDTH-1:0] D_in,
    output logic [WIDTH-1:0] D_out,
    output logic             Bout,
    output logic             Uf_Pulse,
    output logic             Done,
    output logic             Uf_Sticky
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] preset_q;
    logic             done_q, done_d;
    logic             uf_pulse_q;

    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic             core_dec;
    logic [WIDTH-1:0] count;
    logic             is_zero;

    logic en;
    logic uf_event;

    assign en = En_P & En_T;
    // Load (active low) suppresses an underflow in the same cycle.
    assign uf_event = Load & (state_q == ST_RUN) & en & is_zero;

    down_cnt_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .Clock   (Clock),
        .clear   (Clear),
        .load    (core_load),
        .load_val(core_load_val),
        .dec     (core_dec),
        .count   (count),
        .is_zero (is_zero)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter control; zero is always an underflow, never a wrap.
    always_comb begin
        state_d       = state_q;
        core_load     = 1'b0;
        core_load_val = D_in;
        core_dec      = 1'b0;
        if (!Load) begin
            state_d   = ST_RUN;
            core_load = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en) begin
                        if (is_zero) begin
                            if (Auto_Reload) begin
                                core_load     = 1'b1;
                                core_load_val = preset_q;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            core_dec = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Outputs: combinational borrow for cascading and next value of Done.
    always_comb begin
        Bout   = (state_q == ST_RUN) & En_T & is_zero;
        done_d = (state_d == ST_DONE);
    end

    // Preset register, captured only on Load.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            preset_q <= '0;
        end else if (!Load) begin
            preset_q <= D_in;
        end
    end

    // Registered status flags.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            done_q     <= 1'b0;
            uf_pulse_q <= 1'b0;
        end else begin
            done_q     <= done_d;
            uf_pulse_q <= uf_event;
        end
    end

`ifdef SYNC_DOWN_CNT_UF_STICKY_EN
    logic uf_sticky_q;

    // Sticky underflow flag; Load clears it even when an underflow coincides.
    always_ff @(posedge Clock) begin
        if (Clear || !Load) begin
            uf_sticky_q <= 1'b0;
        end else if (uf_event) begin
            uf_sticky_q <= 1'b1;
        end
    end

    assign Uf_Sticky = uf_sticky_q;
`else
    assign Uf_Sticky = 1'b0;
`endif

    assign D_out    = count;
    assign Uf_Pulse = uf_pulse_q;
    assign Done     = done_q;

endmodule
